ss_downsizer: RTL and testbench
===============================

# ss_downsizer

Width-converting stage for the ss stream interface. It accepts wide beats of IN_BYTES bytes and re-emits each one as RATIO narrow beats of IN_BYTES/RATIO bytes, least-significant lane first. It trims empty trailing lanes at end of packet. It sits directly upstream of ss_reg_slice on the narrow side of a datapath and drives that slice's input.

## Interface
- IN_BYTES, default 8: input beat width in bytes; must be divisible by RATIO.
- RATIO, default 4: number of narrow beats per wide beat; must be a power of two, at least 2.
- USER_W, default 4: sideband width; carried unchanged.

- clk  in  1  single clock for the block and both stream sides.
- rst  in  1  asynchronous, active-low reset.
- in.valid  in  1  wide beat valid.
- in.ready  out  1  wide beat accepted when valid and ready are both high.
- in.data  in  8*IN_BYTES  wide payload, byte 0 in bits [7:0].
- in.keep  in  IN_BYTES  byte enables.
- in.last  in  1  final wide beat of the packet.
- in.user  in  USER_W  sideband.
- out.clk / out.rst  out  1  driven directly from clk / rst.
- out.valid, out.ready, out.data (8*IN_BYTES/RATIO), out.keep (IN_BYTES/RATIO), out.last, out.user: same meaning as the in.* signals, narrow side; out.ready is the only input on this side.

## Operation
- Holding register captures data, keep, last and user on every input handshake.
- Registers outside the holding register:
  - state: EMPTY or SEND.
  - idx: current lane, log2(RATIO) bits.
  - end_idx: last lane to emit for the held beat.
- end_idx rules, computed at capture:
  - in.last=0: end_idx = RATIO-1. All lanes are emitted, including all-zero-keep lanes.
  - in.last=1: end_idx = highest lane with any keep bit set.
  - in.last=1 with keep all zero: end_idx = 0. Exactly one beat is emitted with keep=0 and last=1, so the packet boundary is preserved.
- Narrow outputs:
  - out.data / out.keep = lane idx of the holding register.
  - out.user = held user, repeated on every narrow beat.
  - out.last = held last AND (idx == end_idx).
- State transitions:
  - EMPTY: in.ready=1. On in handshake, go to SEND with idx=0.
  - SEND: out.valid=1. On out handshake with idx≠end_idx, idx increments. On out handshake with idx==end_idx:
    - in.valid=1: capture the new beat in the same cycle, stay in SEND, idx=0.
    - in.valid=0: go to EMPTY.
- in.ready = (state==EMPTY) OR (out.valid AND out.ready AND idx==end_idx). This is the only combinational path from out.ready to in.ready. No combinational path exists from in.* to out.*.
- Reset (rst low, asynchronous): state=EMPTY, idx=0, end_idx=0, holding register cleared. Resulting outputs: out.valid=0, out.last=0, out.data=0, out.keep=0, out.user=0, in.ready=1 once reset is released. Asserting reset mid-packet discards the held beat with no flush.

## Timing
- Latency: out.valid rises 1 cycle after the input handshake.
- Throughput: one narrow beat per cycle while out.ready=1. Back-to-back wide beats produce no bubble.
- Once out.valid is high, it and all out payload signals stay stable until the output handshake.
- out.ready low stalls idx. Input is not accepted until the final lane handshakes.

## Structure
- Shared package ss_pkg holds:
  - the state enum (EMPTY, SEND);
  - the functions lane_bytes(IN_BYTES, RATIO) and idx_w(RATIO) = $clog2(RATIO).
- One sub-module, ss_keep_msb_lane: a combinational priority encoder returning the highest non-zero lane of keep, or 0 when keep is all zero. Parameters: IN_BYTES and RATIO.

## Test plan
- Single wide beat, data=0x0706050403020100, keep=0xFF, last=1, out.ready held 1 -> four beats: data 0x0100, 0x0302, 0x0504, 0x0706; keep 0x3 each; last only on the fourth; out.valid first high 1 cycle after the input handshake.
- Two wide beats back-to-back, in.valid held 1 -> eight consecutive narrow beats, no gap. in.ready pulses high only on the cycles where lane 3 is accepted.
- Last beat with keep=0x0F -> two narrow beats, the second with keep=0x3 and last=1. With in.last=0 and keep=0x0F -> four beats, lanes 2 and 3 with keep=0, last=0.
- last=1 with keep=0x00 -> exactly one beat: keep=0, last=1, data = lane 0.
- Random out.ready backpressure (50%) over 200 packets of random length and keep -> reassembled byte stream, keep and last match the input. Payload is stable during every stall.
- Reset asserted in the middle of lane 2 -> out.valid drops immediately (asynchronous). After release, in.ready=1 and the next packet is emitted intact, starting at lane 0.

Source files
------------

// File: rtl/ss_pkg.sv
// ss_pkg: shared types and helpers for the ss stream width converters.
//   ss_state_e  - downsizer control state (EMPTY / SEND)
//   lane_bytes  - bytes per narrow lane for a given wide width and ratio
//   idx_w       - bits needed to index one lane of a wide beat
package ss_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } ss_state_e;

  function automatic int lane_bytes(input int in_bytes, input int ratio);
    return in_bytes / ratio;
  endfunction

  function automatic int idx_w(input int ratio);
    return $clog2(ratio);
  endfunction

endpackage

// File: rtl/ss_keep_msb_lane.sv
// ss_keep_msb_lane: combinational priority encoder over the lanes of a wide
// keep vector. Returns the index of the highest lane that has any keep bit
// set, or 0 when keep is all zero.
//   i_keep  [IN_BYTES]      wide byte enables
//   o_lane  [idx_w(RATIO)]  highest non-empty lane
module ss_keep_msb_lane
  import ss_pkg::*;
#(
  parameter int IN_BYTES = 8,
  parameter int RATIO    = 4
) (
  input  logic [IN_BYTES-1:0]     i_keep,
  output logic [idx_w(RATIO)-1:0] o_lane
);

  localparam int LB = lane_bytes(IN_BYTES, RATIO);
  localparam int IW = idx_w(RATIO);

  // Ascending scan: the last lane that matches wins, giving the highest one.
  always_comb begin
    o_lane = '0;
    for (int l = 0; l < RATIO; l++) begin
      if (|i_keep[l*LB +: LB]) begin
        o_lane = IW'(l);
      end
    end
  end

endmodule

// File: rtl/ss_downsizer.sv
// ss_downsizer: splits each wide ss beat into RATIO narrow beats, lowest lane
// first, trimming empty trailing lanes on the final beat of a packet.
//   i_clk, i_rst_n            clock, async active-low reset
//   i_in_*  / o_in_ready      wide input stream (valid, data, keep, last, user)
//   o_out_* / i_out_ready     narrow output stream
//   o_out_clk, o_out_rst_n    clock/reset forwarded to the downstream slice
//
// state | meaning
// EMPTY | holding register free, input accepted
// SEND  | emitting lane r_idx of the held beat, up to lane r_end_idx
module ss_downsizer
  import ss_pkg::*;
#(
  parameter int IN_BYTES = 8,
  parameter int RATIO    = 4,
  parameter int USER_W   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic [8*IN_BYTES-1:0]          i_in_data,
  input  logic [IN_BYTES-1:0]            i_in_keep,
  input  logic                           i_in_last,
  input  logic [USER_W-1:0]              i_in_user,
  output logic                           o_out_clk,
  output logic                           o_out_rst_n,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [8*IN_BYTES/RATIO-1:0]    o_out_data,
  output logic [IN_BYTES/RATIO-1:0]      o_out_keep,
  output logic                           o_out_last,
  output logic [USER_W-1:0]              o_out_user
);

  localparam int LB = lane_bytes(IN_BYTES, RATIO);
  localparam int LW = 8 * LB;
  localparam int IW = idx_w(RATIO);

  ss_state_e              r_state;
  ss_state_e              w_state_nxt;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          r_end_idx;
  logic [8*IN_BYTES-1:0]  r_data;
  logic [IN_BYTES-1:0]    r_keep;
  logic                   r_last;
  logic [USER_W-1:0]      r_user;

  logic [IW-1:0]          w_msb_lane;
  logic                   w_last_lane;
  logic                   w_in_fire;
  logic                   w_out_fire;

  assign o_out_clk   = i_clk;
  assign o_out_rst_n = i_rst_n;

  ss_keep_msb_lane #(
    .IN_BYTES (IN_BYTES),
    .RATIO    (RATIO)
  ) u_keep_msb_lane (
    .i_keep (i_in_keep),
    .o_lane (w_msb_lane)
  );

  assign w_last_lane = (r_idx == r_end_idx);
  assign w_in_fire   = i_in_valid & o_in_ready;
  assign w_out_fire  = o_out_valid & i_out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_in_fire) w_state_nxt = SEND;
      // A new beat arriving on the final-lane handshake keeps us in SEND.
      SEND:    if (w_out_fire && w_last_lane && !i_in_valid) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // out.ready reaches in.ready only through the final-lane handshake term.
  always_comb begin
    o_out_valid = 1'b0;
    o_in_ready  = 1'b0;
    case (r_state)
      EMPTY: o_in_ready = 1'b1;
      SEND: begin
        o_out_valid = 1'b1;
        o_in_ready  = i_out_ready & w_last_lane;
      end
      default: o_in_ready = 1'b0;
    endcase
  end

  // Non-last beats always emit every lane, even all-zero-keep ones; a last
  // beat with no keep bits still emits lane 0 so the boundary survives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx     <= '0;
      r_end_idx <= '0;
      r_data    <= '0;
      r_keep    <= '0;
      r_last    <= 1'b0;
      r_user    <= '0;
    end else if (w_in_fire) begin
      r_idx     <= '0;
      r_end_idx <= i_in_last ? w_msb_lane : IW'(RATIO - 1);
      r_data    <= i_in_data;
      r_keep    <= i_in_keep;
      r_last    <= i_in_last;
      r_user    <= i_in_user;
    end else if (w_out_fire && !w_last_lane) begin
      r_idx     <= r_idx + 1'b1;
    end
  end

  assign o_out_data = r_data[r_idx*LW +: LW];
  assign o_out_keep = r_keep[r_idx*LB +: LB];
  assign o_out_last = r_last & w_last_lane;
  assign o_out_user = r_user;

endmodule

// File: tb/tb_ss_downsizer.sv
// tb_ss_downsizer: drives wide beats with random valid gaps and random
// out.ready, and predicts the narrow stream from the packet rules with a
// queue-based model (lane count from the highest set keep byte).
module tb_ss_downsizer;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [3:0]  u;
  } wb_t;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        l;
    logic [3:0]  u;
  } nb_t;

  logic        clk;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [63:0] i_in_data;
  logic [7:0]  i_in_keep;
  logic        i_in_last;
  logic [3:0]  i_in_user;
  logic        o_out_clk;
  logic        o_out_rst_n;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [15:0] o_out_data;
  logic [1:0]  o_out_keep;
  logic        o_out_last;
  logic [3:0]  o_out_user;

  ss_downsizer #(.IN_BYTES(8), .RATIO(4), .USER_W(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .i_in_keep   (i_in_keep),
    .i_in_last   (i_in_last),
    .i_in_user   (i_in_user),
    .o_out_clk   (o_out_clk),
    .o_out_rst_n (o_out_rst_n),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_out_keep  (o_out_keep),
    .o_out_last  (o_out_last),
    .o_out_user  (o_out_user)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_vec = 0;
  int  n_err = 0;
  wb_t stim_q[$];
  nb_t exp_q[$];
  nb_t log_q[$];
  int  rdy_pct = 100;
  int  vld_pct = 100;
  logic fired = 1'b0;
  logic prev_stall = 1'b0;
  nb_t  prev_out;
  logic [15:0] t1_data [4] = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a non-last beat yields all 4 lanes; a last beat yields lanes up
  // to the one holding the highest set keep byte, or just lane 0 if keep=0.
  task automatic model_push(input wb_t w);
    int hi = -1;
    int n;
    nb_t e;
    for (int b = 0; b < 8; b++) if (w.k[b]) hi = b;
    if (!w.l)        n = 4;
    else if (hi < 0) n = 1;
    else             n = hi / 2 + 1;
    for (int ln = 0; ln < n; ln++) begin
      e.d = w.d[ln*16 +: 16];
      e.k = w.k[ln*2 +: 2];
      e.l = w.l && (ln == n - 1);
      e.u = w.u;
      exp_q.push_back(e);
    end
  endtask

  task automatic cycle();
    nb_t cur;
    nb_t e;
    @(posedge clk);
    #1;
    if (fired) begin
      i_in_valid = 1'b0;
      fired = 1'b0;
    end
    if (!i_in_valid && stim_q.size() > 0 && $urandom_range(99) < vld_pct) begin
      i_in_valid = 1'b1;
      i_in_data  = stim_q[0].d;
      i_in_keep  = stim_q[0].k;
      i_in_last  = stim_q[0].l;
      i_in_user  = stim_q[0].u;
    end
    i_out_ready = ($urandom_range(99) < rdy_pct);
    @(negedge clk);
    cur = '{d: o_out_data, k: o_out_keep, l: o_out_last, u: o_out_user};
    chk("out_valid", o_out_valid, exp_q.size() != 0);
    chk("in_ready", o_in_ready, exp_q.size() == 0 || (exp_q.size() == 1 && i_out_ready));
    if (prev_stall) chk("stall_stable", cur, prev_out);
    if (o_out_valid && i_out_ready) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("beat", cur, e);
      end
      log_q.push_back(cur);
    end
    prev_stall = o_out_valid && !i_out_ready;
    prev_out   = cur;
    if (i_in_valid && o_in_ready) begin
      model_push(stim_q.pop_front());
      fired = 1'b1;
    end
  endtask

  task automatic run_idle(input int budget);
    int c = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && c < budget) begin
      cycle();
      c++;
    end
    chk("drain", stim_q.size() + exp_q.size(), 0);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    fired = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [3:0] u);
    wb_t w;
    w.d = d; w.k = k; w.l = l; w.u = u;
    stim_q.push_back(w);
  endtask

  initial begin
    int c;
    int nb;
    logic [7:0] k;
    rst_n = 1'b0;
    i_in_valid = 1'b0;
    i_in_data = '0;
    i_in_keep = '0;
    i_in_last = 1'b0;
    i_in_user = '0;
    i_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_data", {o_out_data, o_out_keep, o_out_last, o_out_user}, 0);
    chk("rst_out_rst_n", o_out_rst_n, rst_n);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", o_in_ready, 1);
    chk("rel_out_valid", o_out_valid, 0);
    chk("out_clk", o_out_clk, clk);

    // Full 8-byte last beat, no backpressure.
    rdy_pct = 100; vld_pct = 100;
    log_q.delete();
    push_beat(64'h0706050403020100, 8'hFF, 1'b1, 4'h5);
    run_idle(50);
    chk("t1_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("t1_data", log_q[i].d, t1_data[i]);
      chk("t1_keep", log_q[i].k, 2'b11);
      chk("t1_last", log_q[i].l, i == 3);
    end

    // Back-to-back wide beats.
    log_q.delete();
    push_beat({$urandom, $urandom}, 8'hFF, 1'b0, 4'h1);
    push_beat({$urandom, $urandom}, 8'hFF, 1'b1, 4'h2);
    run_idle(50);
    chk("t2_count", log_q.size(), 8);

    // Trimmed last beat, then the same keep on a non-last beat.
    log_q.delete();
    push_beat(64'h1122334455667788, 8'h0F, 1'b1, 4'h3);
    run_idle(50);
    chk("t3a_count", log_q.size(), 2);
    log_q.delete();
    push_beat(64'h99AABBCCDDEEFF00, 8'h0F, 1'b0, 4'h4);
    push_beat(64'h0, 8'h03, 1'b1, 4'h4);
    run_idle(50);
    chk("t3b_count", log_q.size(), 5);

    // Empty last beat.
    log_q.delete();
    push_beat(64'hCAFEF00DDEADBEEF, 8'h00, 1'b1, 4'h6);
    run_idle(50);
    chk("t4_count", log_q.size(), 1);
    if (log_q.size() > 0) chk("t4_beat", log_q[0], {16'hBEEF, 2'b00, 1'b1, 4'h6});

    // Random packets with random valid gaps and 50% out.ready.
    rdy_pct = 50; vld_pct = 70;
    for (int p = 0; p < 200; p++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        k = 8'($urandom);
        if ($urandom_range(9) == 0) k = 8'h00;
        push_beat({$urandom, $urandom}, k, b == nb - 1, 4'($urandom));
      end
    end
    run_idle(20000);

    // Reset in the middle of lane 2.
    rdy_pct = 100; vld_pct = 100;
    log_q.delete();
    push_beat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1, 4'h7);
    c = 0;
    while (log_q.size() < 2 && c < 50) begin
      cycle();
      c++;
    end
    chk("pre_rst_lanes", log_q.size(), 2);
    @(posedge clk);
    #2;
    chk("lane2_valid", o_out_valid, 1);
    chk("lane2_data", o_out_data, 16'h0D0C);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", o_out_valid, 0);
    chk("async_rst_keep", o_out_keep, 0);
    exp_q.delete();
    stim_q.delete();
    i_in_valid = 1'b0;
    i_out_ready = 1'b0;
    fired = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", o_in_ready, 1);
    chk("post_rst_valid", o_out_valid, 0);
    log_q.delete();
    push_beat(64'h8877665544332211, 8'h3F, 1'b1, 4'h9);
    run_idle(50);
    chk("post_rst_count", log_q.size(), 3);
    if (log_q.size() > 0) chk("post_rst_lane0", log_q[0].d, 16'h2211);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
